branch_resolve: RTL and testbench

ID-stage branch resolution unit for the 5-stage pipelined MIPS core. Consumes the register-equality flag produced by the ID-stage comparator and the decoded beq/bne controls, and decides PC redirect, IF/ID flush and branch-operand hazard stalls. Sits between the ID-stage comparator/decoder and the PC select mux / IF-ID pipeline register, alongside the load-use hazard unit.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_resolve_if.sv | 46 ++++
 rtl/branch_hazard_detect.sv | 30 +++
 rtl/branch_resolve.sv | 107 ++++++++++
 tb/tb_branch_resolve.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the ID-stage branch resolution unit.
// CNT_W sizes the statistics counters built with BRANCH_STATS_EN.
package branch_pkg;

    typedef enum logic [0:0] {IDLE, STALL} state_e;

    typedef logic [1:0] need_t;

    localparam need_t      NEED_0   = 2'd0;
    localparam need_t      NEED_1   = 2'd1;
    localparam need_t      NEED_2   = 2'd2;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned CNT_W   = 32;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_hit(logic [4:0] dst, logic [4:0] rs, logic [4:0] rt);
        return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle between the ID-stage decoder/comparator and the branch resolution unit.
// Counter signals exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_if;
    import branch_pkg::*;

    logic             Branch;
    logic             BranchNE;
    logic [4:0]       Rs;
    logic [4:0]       Rt;
    logic             EqualResult;
    logic [31:0]      PCPlus4;
    logic [31:0]      SignExtImm;
    logic             EX_RegWrite;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteReg;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteReg;
    logic             Stall;
    logic             PCSrc;
    logic             IF_Flush;
    logic [31:0]      BranchTarget;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] TakenCount;
    logic [CNT_W-1:0] StallCount;
`endif

    modport master (
        output Branch, BranchNE, Rs, Rt, EqualResult, PCPlus4, SignExtImm,
               EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
        input  Stall, PCSrc, IF_Flush, BranchTarget
`ifdef BRANCH_STATS_EN
        , input BranchCount, TakenCount, StallCount
`endif
    );

    modport slave (
        input  Branch, BranchNE, Rs, Rt, EqualResult, PCPlus4, SignExtImm,
               EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
        output Stall, PCSrc, IF_Flush, BranchTarget
`ifdef BRANCH_STATS_EN
        , output BranchCount, TakenCount, StallCount
`endif
    );

endinterface

// File: rtl/branch_hazard_detect.sv
// Combinational branch-operand hazard classifier: how many stall cycles the
// branch in ID needs before its forwarded operands are valid.
module branch_hazard_detect
    import branch_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_write_reg_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_write_reg_i,
    output need_t      need_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = reg_hit(ex_write_reg_i, rs_i, rt_i);
    assign mem_hit = reg_hit(mem_write_reg_i, rs_i, rt_i);

    // Later assignments have higher priority, giving the max of all needs.
    always_comb begin
        need_o = NEED_0;
        if (mem_mem_read_i && mem_hit) need_o = NEED_1;
        if (ex_reg_write_i && !ex_mem_read_i && ex_hit) need_o = NEED_1;
        if (ex_mem_read_i && ex_hit) need_o = NEED_2;
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: PC redirect, IF/ID flush and operand-hazard stalls.
// Optional BRANCH_STATS_EN adds saturating branch/taken/stall counters.
module branch_resolve
    import branch_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    branch_resolve_if.slave bus
);

    state_e     state_q, state_d;
    logic [0:0] cnt_q, cnt_d;
    need_t      need;
    logic       br;
    logic       stall;
    logic       pcsrc;
    logic       resolve;

    branch_hazard_detect u_hazard (
        .rs_i            (bus.Rs),
        .rt_i            (bus.Rt),
        .ex_reg_write_i  (bus.EX_RegWrite),
        .ex_mem_read_i   (bus.EX_MemRead),
        .ex_write_reg_i  (bus.EX_WriteReg),
        .mem_mem_read_i  (bus.MEM_MemRead),
        .mem_write_reg_i (bus.MEM_WriteReg),
        .need_o          (need)
    );

    assign br = bus.Branch | bus.BranchNE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        pcsrc   = 1'b0;
        resolve = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (br && (need != NEED_0)) begin
                    stall = 1'b1;
                    if (need == NEED_2) begin
                        state_d = STALL;
                        cnt_d   = 1'b0;
                    end
                end else if (br) begin
                    resolve = 1'b1;
                    // beq wins if both decodes are set.
                    pcsrc   = bus.Branch ? bus.EqualResult : !bus.EqualResult;
                end
            end
            STALL: begin
                stall = 1'b1;
                if (cnt_q == 1'b0) state_d = IDLE;
                else               cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Stall        = stall;
    assign bus.PCSrc        = pcsrc;
    assign bus.IF_Flush     = pcsrc;
    assign bus.BranchTarget = bus.PCPlus4 + {bus.SignExtImm[29:0], 2'b00};

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (resolve && !(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
        if (pcsrc && !(&taken_cnt_q))    taken_cnt_d  = taken_cnt_q + 1'b1;
        if (stall && !(&stall_cnt_q))    stall_cnt_d  = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.BranchCount = branch_cnt_q;
    assign bus.TakenCount  = taken_cnt_q;
    assign bus.StallCount  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized traffic
// against a cycle-count reference model of the branch stall/resolve rules.
module tb_branch_resolve;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    branch_resolve_if bus ();

    branch_resolve dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: stall cycles still owed from a load in EX, plus event tallies.
    int          m_owed = 0;
    int unsigned m_branches = 0;
    int unsigned m_taken = 0;
    int unsigned m_stalls = 0;
    logic        e_stall;
    logic        e_pcsrc;
    logic [31:0] e_tgt;

    function automatic bit uses(logic [4:0] w);
        return (w != 0) && (w == bus.Rs || w == bus.Rt);
    endfunction

    function automatic int needed_cycles();
        int n = 0;
        if (bus.MEM_MemRead && uses(bus.MEM_WriteReg)) n = 1;
        if (bus.EX_RegWrite && !bus.EX_MemRead && uses(bus.EX_WriteReg)) n = 1;
        if (bus.EX_MemRead && uses(bus.EX_WriteReg)) n = 2;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        bit br;
        int n;
        br = bus.Branch || bus.BranchNE;
        n  = needed_cycles();
        e_stall = 1'b0;
        e_pcsrc = 1'b0;
        if (m_owed > 0) e_stall = 1'b1;
        else if (br && n > 0) e_stall = 1'b1;
        else if (br) e_pcsrc = bus.Branch ? bus.EqualResult : !bus.EqualResult;
        e_tgt = bus.PCPlus4 + bus.SignExtImm * 32'd4;
    endtask

    task automatic check_all(input string tag);
        predict();
        chk({tag, "_stall"}, {31'd0, bus.Stall}, {31'd0, e_stall});
        chk({tag, "_pcsrc"}, {31'd0, bus.PCSrc}, {31'd0, e_pcsrc});
        chk({tag, "_flush"}, {31'd0, bus.IF_Flush}, {31'd0, e_pcsrc});
        chk({tag, "_target"}, bus.BranchTarget, e_tgt);
`ifdef BRANCH_STATS_EN
        chk({tag, "_bcnt"}, bus.BranchCount, m_branches);
        chk({tag, "_tcnt"}, bus.TakenCount, m_taken);
        chk({tag, "_scnt"}, bus.StallCount, m_stalls);
`endif
    endtask

    // Check at negedge+1, advance the model across the posedge, return at next negedge.
    task automatic step(input string tag);
        bit br;
        #1 check_all(tag);
        predict();
        br = bus.Branch || bus.BranchNE;
        if (!rst_n) begin
            m_owed = 0;
            m_branches = 0;
            m_taken = 0;
            m_stalls = 0;
        end else begin
            if (e_stall) m_stalls++;
            if (e_pcsrc) m_taken++;
            if (br && !e_stall) m_branches++;
            if (m_owed > 0) m_owed--;
            else if (br && needed_cycles() == 2) m_owed = 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.Branch = 0; bus.BranchNE = 0; bus.Rs = 0; bus.Rt = 0;
        bus.EqualResult = 0; bus.PCPlus4 = 0; bus.SignExtImm = 0;
        bus.EX_RegWrite = 0; bus.EX_MemRead = 0; bus.EX_WriteReg = 0;
        bus.MEM_MemRead = 0; bus.MEM_WriteReg = 0;
    endtask

    task automatic clear_hazards();
        bus.EX_RegWrite = 0; bus.EX_MemRead = 0; bus.EX_WriteReg = 0;
        bus.MEM_MemRead = 0; bus.MEM_WriteReg = 0;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        step("reset");
        bus.Branch = 1;
        step("reset_br_noeffect");
        bus.Branch = 0;
        rst_n = 1;
        step("idle");

        // beq taken, no hazards
        bus.Branch = 1; bus.EqualResult = 1;
        bus.PCPlus4 = 32'h0040_0010; bus.SignExtImm = 32'h0000_0003;
        #1;
        chk("beq_pcsrc", {31'd0, bus.PCSrc}, 32'd1);
        chk("beq_flush", {31'd0, bus.IF_Flush}, 32'd1);
        chk("beq_stall", {31'd0, bus.Stall}, 32'd0);
        chk("beq_target", bus.BranchTarget, 32'h0040_001C);
        step("beq");

        // bne not taken, negative offset
        bus.Branch = 0; bus.BranchNE = 1; bus.EqualResult = 1;
        bus.PCPlus4 = 32'h0000_1000; bus.SignExtImm = 32'hFFFF_FFFF;
        #1;
        chk("bne_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
        chk("bne_target", bus.BranchTarget, 32'h0000_0FFC);
        step("bne");

        // ALU producer in EX: one stall, then resolve
        bus.BranchNE = 0; bus.Branch = 1; bus.EqualResult = 1; bus.Rs = 8; bus.Rt = 3;
        bus.EX_RegWrite = 1; bus.EX_WriteReg = 8;
        #1 chk("alu_stall", {31'd0, bus.Stall}, 32'd1);
        step("alu_s1");
        clear_hazards();
        #1 chk("alu_resolve", {31'd0, bus.PCSrc}, 32'd1);
        step("alu_res");

        // Load in EX: two stalls, resolve in the third cycle
        rst_n = 0;
        step("rst2");
        rst_n = 1;
        bus.Branch = 1; bus.Rs = 4; bus.Rt = 9; bus.EqualResult = 0;
        bus.EX_MemRead = 1; bus.EX_WriteReg = 9;
        #1 chk("ld_stall1", {31'd0, bus.Stall}, 32'd1);
        step("ld_s1");
        clear_hazards();
        #1 chk("ld_stall2", {31'd0, bus.Stall}, 32'd1);
        chk("ld_pcsrc2", {31'd0, bus.PCSrc}, 32'd0);
        step("ld_s2");
        #1 chk("ld_resolve_stall", {31'd0, bus.Stall}, 32'd0);
        chk("ld_resolve_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
        step("ld_res");
`ifdef BRANCH_STATS_EN
        chk("ld_stallcount", bus.StallCount, 32'd2);
        chk("ld_branchcount", bus.BranchCount, 32'd1);
`endif

        // Writes to register 0 never cause a hazard
        bus.Rs = 0; bus.Rt = 0; bus.EX_RegWrite = 1; bus.EX_WriteReg = 0;
        bus.EqualResult = 1;
        #1 chk("r0_stall", {31'd0, bus.Stall}, 32'd0);
        step("r0");
        clear_hazards();

        // Load in MEM: one stall
        bus.Rs = 5; bus.MEM_MemRead = 1; bus.MEM_WriteReg = 5;
        #1 chk("mem_stall", {31'd0, bus.Stall}, 32'd1);
        step("mem_s1");
        clear_hazards();
        step("mem_res");

        // Reset pulsed while in STALL
        bus.Rs = 6; bus.EX_MemRead = 1; bus.EX_WriteReg = 6; bus.EqualResult = 0;
        step("rstmid_s1");
        clear_hazards();
        #1 chk("rstmid_in_stall", {31'd0, bus.Stall}, 32'd1);
        rst_n = 0;
        m_owed = 0; m_branches = 0; m_taken = 0; m_stalls = 0;
        #1 chk("rstmid_stall_drop", {31'd0, bus.Stall}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rstmid_cnt_zero", bus.StallCount, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1;
        step("rstmid_after");

        // Randomized traffic with small register indices to provoke collisions
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            bus.Branch       = (kind == 1) || (kind == 3);
            bus.BranchNE     = (kind == 2) || (kind == 3);
            bus.Rs           = 5'($urandom_range(0, 3));
            bus.Rt           = 5'($urandom_range(0, 3));
            bus.EqualResult  = 1'($urandom_range(0, 1));
            bus.PCPlus4      = $urandom;
            bus.SignExtImm   = $urandom;
            bus.EX_RegWrite  = 1'($urandom_range(0, 1));
            bus.EX_MemRead   = ($urandom_range(0, 3) == 0);
            bus.EX_WriteReg  = 5'($urandom_range(0, 3));
            bus.MEM_MemRead  = ($urandom_range(0, 2) == 0);
            bus.MEM_WriteReg = 5'($urandom_range(0, 3));
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
